// File: rtl/mctrl_pkg.sv
// Package: mctrl_pkg
// Shared definitions for the multi-cycle main controller:
//   - state_t      : 4-bit controller state encoding (IDLE..IMMWB)
//   - OP_*         : supported instruction opcodes (IR[31:26])
//   - alu_op_t, alu_src_b_t, pc_source_t : datapath select encodings
//   - ctrl_t       : the full Moore control vector driven onto the datapath
//   - op_supported : true for any opcode the controller can sequence
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_IMM   = 6'd7;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_IMM: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mctrl_outdec.sv
// Module: mctrl_outdec
// Purely combinational control-vector decoder for the multi-cycle controller.
// Ports:
//   state     in  state_t  current controller state
//   mem_ready in  1        memory handshake (only used in FETCH and MEMWR)
//   op_legal  in  1        opcode is one the controller supports (used in DECODE)
//   ctrl      out ctrl_t   datapath control vector for this cycle
module mctrl_outdec
  import mctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   op_legal,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // IR and PC+4 are only committed on the cycle the fetch completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut
        ctrl.alu_src_b  = SRCB_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = ~op_legal;
        ctrl.instr_done = ~op_legal;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        // A store only ends once memory accepts it
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_IMM;
      end
      S_IMMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Module: multicycle_ctrl
// Multi-cycle main controller: sequences a shared ALU/memory/regfile datapath
// one instruction at a time (R-type, lw, sw, beq, j, imm-ALU), waiting on the
// memory ready handshake and parking in IDLE at an instruction boundary when
// run is low.
// Ports:
//   clk, rst_n (synchronous, active-low), run, opcode[5:0], mem_ready
//   pc_write, pc_write_cond, pc_source[1:0], iord, mem_read, mem_write,
//   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], instr_done, illegal_op, state_o[3:0]
// Optional build macro MCTRL_PERF_EN: adds the wrapping counters
// cycle_cnt / instr_cnt / stall_cnt [CNT_W-1:0].
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             illegal_op,
`ifdef MCTRL_PERF_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [3:0]       state_o
);

  state_t state_reg;
  state_t state_next;
  state_t boundary_next;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Where every final state goes: next instruction or park
  assign boundary_next = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_IMM:       state_next = S_IMMEX;
          default:      state_next = boundary_next;  // illegal ends here
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = boundary_next;
      S_EXEC:   state_next = S_ALUWB;
      S_IMMEX:  state_next = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB:
                state_next = boundary_next;
      default:  state_next = S_IDLE;
    endcase
  end

  mctrl_outdec u_outdec (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .op_legal  (op_supported(opcode)),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign state_o       = state_reg;

`ifdef MCTRL_PERF_EN
  // Index 0: active cycles, 1: completed instructions, 2: memory stall cycles
  logic [2:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [3];

  assign cnt_inc[0] = (state_reg != S_IDLE);
  assign cnt_inc[1] = ctrl.instr_done;
  assign cnt_inc[2] = ~mem_ready & ((state_reg == S_FETCH) |
                                    (state_reg == S_MEMRD) |
                                    (state_reg == S_MEMWR));

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) cnt_reg[i] <= '0;
      else        cnt_reg[i] <= cnt_reg[i] + CNT_W'(cnt_inc[i]);
    end
  end

  assign cycle_cnt = cnt_reg[0];
  assign instr_cnt = cnt_reg[1];
  assign stall_cnt = cnt_reg[2];
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench: tb_multicycle_ctrl
// Randomized instruction stream against a per-instruction summary model.
// The driver pushes the expected summary of each instruction (latency, number
// of cycles each control is asserted, final-cycle selects) into a scoreboard
// queue; the monitor accumulates what the DUT shows between instruction start
// and instr_done and compares on every instr_done. A memory responder supplies
// mem_ready with per-access wait counts chosen by the driver.
module tb_multicycle_ctrl;
  import mctrl_pkg::*;

  localparam int CW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state_o;
`ifdef MCTRL_PERF_EN
  logic [CW-1:0] cycle_cnt, instr_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op),
`ifdef MCTRL_PERF_EN
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt),
`endif
    .state_o(state_o)
  );

  typedef struct {
    logic [5:0]  op;
    int          lat, rd, wr, rw, pcw, pcwc, irw, io, ill;
    logic [3:0]  fin;   // {reg_dst, mem_to_reg, pc_source} in the final cycle
    logic [27:0] alu;   // cycle counts: {a=1, b=01, b=10, b=11, op=01, op=10, op=11}
    bit          park;
  } exp_t;

  exp_t exp_q[$];
  int   access_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  bit   mon_en = 1'b0;
  int   total_lat = 0, total_stall = 0, n_instr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural summary of one instruction, straight from the latency and
  // per-state control tables of the controller description.
  function automatic exp_t model(input logic [5:0] op, input int wf, input int wm, input bit park);
    exp_t e;
    bit is_r   = (op == 6'd0);
    bit is_lw  = (op == 6'd35);
    bit is_sw  = (op == 6'd43);
    bit is_beq = (op == 6'd4);
    bit is_j   = (op == 6'd2);
    bit is_imm = (op == 6'd7);
    bit legal  = is_r | is_lw | is_sw | is_beq | is_j | is_imm;
    e.op   = op;
    e.park = park;
    if (is_lw)                e.lat = 5 + wf + wm;
    else if (is_sw)           e.lat = 4 + wf + wm;
    else if (is_r || is_imm)  e.lat = 4 + wf;
    else if (is_beq || is_j)  e.lat = 3 + wf;
    else                      e.lat = 2 + wf;
    e.rd   = 1 + wf + (is_lw ? 1 + wm : 0);
    e.wr   = is_sw ? 1 + wm : 0;
    e.io   = (is_lw || is_sw) ? 1 + wm : 0;
    e.rw   = (is_r || is_lw || is_imm) ? 1 : 0;
    e.pcw  = 1 + (is_j ? 1 : 0);
    e.pcwc = is_beq ? 1 : 0;
    e.irw  = 1;
    e.ill  = legal ? 0 : 1;
    e.fin  = is_r ? 4'b1000 : is_lw ? 4'b0100 : is_beq ? 4'b0001 : is_j ? 4'b0010 : 4'b0000;
    e.alu  = {4'(is_lw | is_sw | is_r | is_beq | is_imm), 4'(1 + wf),
              4'(is_lw | is_sw | is_imm), 4'd1,
              4'(is_beq), 4'(is_r), 4'(is_imm)};
    return e;
  endfunction

  function automatic logic any_out();
    return pc_write | pc_write_cond | (|pc_source) | iord | mem_read | mem_write |
           ir_write | reg_dst | mem_to_reg | reg_write | alu_src_a | (|alu_src_b) |
           (|alu_op) | instr_done | illegal_op;
  endfunction

  // Memory responder: each access takes the next wait count from access_q.
  initial begin
    int  left = 0;
    bit  busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        busy = 1'b0;
        access_q.delete();
        mem_ready = 1'b0;
      end else if (mem_read || mem_write) begin
        if (!busy) begin
          checks++;
          if (access_q.size() == 0) begin
            errors++;
            $display("FAIL access_start: got unexpected memory access, expected none (t=%0t)", $time);
            left = 0;
          end else left = access_q.pop_front();
          busy = 1'b1;
        end
        if (left == 0) begin
          mem_ready = 1'b1;
          busy = 1'b0;
        end else begin
          mem_ready = 1'b0;
          left--;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));  // must be ignored here
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit  in_instr = 1'b0, post_chk = 1'b0, post_park = 1'b0;
    int  lat = 0, rd = 0, wr = 0, rw = 0, pcw = 0, pcwc = 0, irw = 0, io = 0, ill = 0;
    int  a1 = 0, b01 = 0, b10 = 0, b11 = 0, o01 = 0, o10 = 0, o11 = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_instr = 1'b0;
        post_chk = 1'b0;
      end else begin
        if (post_chk) begin
          post_chk = 1'b0;
          if (post_park) check("idle_after_park", {any_out(), state_o}, {1'b0, S_IDLE});
          else           check("fetch_after_done", {mem_read, alu_src_b}, 3'b101);
        end
        if (any_out()) begin
          if (!in_instr) begin
            in_instr = 1'b1;
            lat = 0; rd = 0; wr = 0; rw = 0; pcw = 0; pcwc = 0; irw = 0; io = 0; ill = 0;
            a1 = 0; b01 = 0; b10 = 0; b11 = 0; o01 = 0; o10 = 0; o11 = 0;
          end
          lat++;
          rd += int'(mem_read);   wr += int'(mem_write);  rw += int'(reg_write);
          pcw += int'(pc_write);  pcwc += int'(pc_write_cond);
          irw += int'(ir_write);  io += int'(iord);       ill += int'(illegal_op);
          a1  += int'(alu_src_a);
          b01 += int'(alu_src_b == 2'b01); b10 += int'(alu_src_b == 2'b10);
          b11 += int'(alu_src_b == 2'b11);
          o01 += int'(alu_op == 2'b01); o10 += int'(alu_op == 2'b10); o11 += int'(alu_op == 2'b11);
          if (instr_done) begin
            in_instr = 1'b0;
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL scoreboard_empty: got instr_done, expected none (t=%0t)", $time);
            end else begin
              e = exp_q.pop_front();
              $display("txn %0d op=%0d latency=%0d expected=%0d park=%0d",
                       done_cnt, e.op, lat, e.lat, e.park);
              check("latency",       64'(lat),  64'(e.lat));
              check("mem_read_cyc",  64'(rd),   64'(e.rd));
              check("mem_write_cyc", 64'(wr),   64'(e.wr));
              check("iord_cyc",      64'(io),   64'(e.io));
              check("reg_write_cyc", 64'(rw),   64'(e.rw));
              check("pc_write_cyc",  64'(pcw),  64'(e.pcw));
              check("pc_wcond_cyc",  64'(pcwc), 64'(e.pcwc));
              check("ir_write_cyc",  64'(irw),  64'(e.irw));
              check("illegal_cyc",   64'(ill),  64'(e.ill));
              check("final_sel",     {reg_dst, mem_to_reg, pc_source}, e.fin);
              check("alu_profile",   {4'(a1), 4'(b01), 4'(b10), 4'(b11), 4'(o01), 4'(o10), 4'(o11)}, e.alu);
              post_chk  = 1'b1;
              post_park = e.park;
            end
          end
        end
      end
    end
  end

  bit parked = 1'b1;
  bit abort = 1'b0;

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit park);
    exp_t e;
    int   target;
    bit   is_mem = (op == OP_LW) || (op == OP_SW);
    if (parked) begin
      run = 1'b1;
      @(posedge clk); #1;
      check("run_resume", {mem_read, alu_src_b}, 3'b101);
      parked = 1'b0;
    end
    access_q.push_back(wf);
    if (is_mem) access_q.push_back(wm);
    e = model(op, wf, wm, park);
    exp_q.push_back(e);
    total_lat   += e.lat;
    total_stall += wf + (is_mem ? wm : 0);
    n_instr++;
    opcode = op;
    if (park) run = 1'b0;  // dropped mid-instruction; only the boundary sees it
    target = done_cnt + 1;
    for (int c = 0; c < 60 && done_cnt < target; c++) begin
      @(posedge clk); #1;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no instr_done for op %0d, expected one within 60 cycles", op);
      abort = 1'b1;
    end
    if (park) begin
      parked = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int         idx;
    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ;   ops[4] = OP_J;  ops[5] = OP_IMM;

    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", {any_out(), state_o}, {1'b0, S_IDLE});
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_hold_run0", {any_out(), state_o}, {1'b0, S_IDLE});
    mon_en = 1'b1;

    // Directed: R-type, lw with 2 wait cycles, sw then beq, illegal, R with park
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    if (!abort) run_instr(OP_LW, 0, 2, 1'b0);
    if (!abort) run_instr(OP_SW, 0, 0, 1'b0);
    if (!abort) run_instr(OP_BEQ, 0, 0, 1'b0);
    if (!abort) run_instr(6'h3F, 0, 0, 1'b0);
    if (!abort) run_instr(OP_RTYPE, 0, 0, 1'b1);

    for (int n = 0; n < 150 && !abort; n++) begin
      idx = int'($urandom_range(0, 6));
      if (idx < 6) op = ops[idx];
      else begin
        op = 6'($urandom_range(0, 63));
        while (op_supported(op)) op = 6'($urandom_range(0, 63));
      end
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0));
    end
    if (!abort) run_instr(OP_J, 1, 0, 1'b1);  // end parked in IDLE

    if (!abort) begin
`ifdef MCTRL_PERF_EN
      check("perf_cycle_cnt", 64'(cycle_cnt), 64'(total_lat));
      check("perf_instr_cnt", 64'(instr_cnt), 64'(n_instr));
      check("perf_stall_cnt", 64'(stall_cnt), 64'(total_stall));
`endif
      // Reset in the middle of a stalled store
      mon_en = 1'b0;
      access_q.push_back(0);
      access_q.push_back(20);
      opcode = OP_SW;
      run = 1'b1;
      for (int c = 0; c < 20 && !mem_write; c++) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check("memwr_stalled", {mem_write, iord, instr_done}, 3'b110);
      run = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("reset_mid_memwr", {any_out(), mem_write, state_o}, {1'b0, 1'b0, S_IDLE});
`ifdef MCTRL_PERF_EN
      check("perf_reset", {cycle_cnt, instr_cnt, stall_cnt}, '0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
